snn_reward_learner: RTL and testbench

Reward-modulated plasticity stage that sits directly upstream of the two-neuron SNN core and drives its four signed 5-bit synaptic weights. It turns the per-step combinational weight guesses into persistent, clocked learning state.
- It tracks pre- and post-synaptic spike traces and accumulates per-synapse eligibility.
- On a reward event it folds eligibility into the weights through a short sequential update FSM.

---
 rtl/snn_reward_learner.sv | 160 ++++++++++++++++
 tb/tb_snn_reward_learner.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_reward_learner.sv
// rtl/snn_reward_learner.sv - reward-modulated STDP learner driving four SNN synaptic weights
module snn_reward_learner #(
    parameter int TRACE_MAX   = 15,
    parameter int TRACE_DECAY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clear,
    input  logic              step,
    input  logic [1:0]        pre_spk,
    input  logic [1:0]        post_spk,
    input  logic              reward_valid,
    input  logic              reward_sign,
    input  logic [1:0]        reward_mag,
    output logic signed [4:0] weight1,
    output logic signed [4:0] weight2,
    output logic signed [4:0] weight3,
    output logic signed [4:0] weight4,
    output logic              busy,
    output logic              update_done,
    output logic              overrun
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_APPLY = 2'd1, S_DONE = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [1:0]        k;
    logic [3:0]        tr_pre [2];
    logic [3:0]        tr_post [2];
    logic [3:0]        tr_pre_nxt [2];
    logic [3:0]        tr_post_nxt [2];
    logic signed [5:0] elig [4];
    logic signed [5:0] elig_nxt [4];
    logic signed [7:0] acc;
    logic signed [4:0] w [4];
    logic signed [5:0] delta;
    logic signed [6:0] w_sum;
    logic signed [4:0] w_upd;
    logic              sign_q;
    logic [1:0]        mag_q;
    logic              step_acc, reward_acc, drop;

    assign step_acc   = step && ena && !busy;
    assign reward_acc = reward_valid && ena && (state == S_IDLE);
    assign drop       = (step || reward_valid) && ena && busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (reward_acc) state_nxt = S_APPLY;
            S_APPLY: if (k == 2'd3) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (clear) state_nxt = S_IDLE;
    end

    always_comb begin
        busy        = 1'b0;
        update_done = 1'b0;
        case (state)
            S_APPLY: busy = 1'b1;
            S_DONE: begin
                busy        = 1'b1;
                update_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Synapse n = 2*i + j connects pre neuron i to post neuron j; all terms use pre-step traces.
    always_comb begin
        tr_pre_nxt  = tr_pre;
        tr_post_nxt = tr_post;
        elig_nxt    = elig;
        acc         = '0;
        for (int i = 0; i < 2; i++) begin
            tr_pre_nxt[i]  = pre_spk[i] ? 4'(TRACE_MAX) :
                             (tr_pre[i] >= 4'(TRACE_DECAY)) ? tr_pre[i] - 4'(TRACE_DECAY) : 4'd0;
            tr_post_nxt[i] = post_spk[i] ? 4'(TRACE_MAX) :
                             (tr_post[i] >= 4'(TRACE_DECAY)) ? tr_post[i] - 4'(TRACE_DECAY) : 4'd0;
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                acc = {{2{elig[2*i+j][5]}}, elig[2*i+j]};
                if (post_spk[j]) acc = acc + $signed({6'd0, tr_pre[i][3:2]});
                if (pre_spk[i])  acc = acc - $signed({6'd0, tr_post[j][3:2]});
                if (acc > 8'sd31)       elig_nxt[2*i+j] = 6'h1f;
                else if (acc < -8'sd32) elig_nxt[2*i+j] = 6'h20;
                else                    elig_nxt[2*i+j] = acc[5:0];
            end
        end
    end

    always_comb begin
        delta = elig[k] >>> (2'd3 - mag_q);
        if (sign_q) w_sum = {{2{w[k][4]}}, w[k]} + {delta[5], delta};
        else        w_sum = {{2{w[k][4]}}, w[k]} - {delta[5], delta};
        if (w_sum > 7'sd15)       w_upd = 5'h0f;
        else if (w_sum < -7'sd16) w_upd = 5'h10;
        else                      w_upd = w_sum[4:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= 2'd0;
            sign_q  <= 1'b0;
            mag_q   <= 2'd0;
            overrun <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                tr_pre[n]  <= 4'd0;
                tr_post[n] <= 4'd0;
            end
            for (int n = 0; n < 4; n++) begin
                elig[n] <= '0;
                w[n]    <= '0;
            end
        end else if (clear) begin
            k       <= 2'd0;
            sign_q  <= 1'b0;
            mag_q   <= 2'd0;
            overrun <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                tr_pre[n]  <= 4'd0;
                tr_post[n] <= 4'd0;
            end
            for (int n = 0; n < 4; n++) begin
                elig[n] <= '0;
                w[n]    <= '0;
            end
        end else begin
            if (step_acc) begin
                tr_pre  <= tr_pre_nxt;
                tr_post <= tr_post_nxt;
                elig    <= elig_nxt;
            end
            if (reward_acc) begin
                sign_q <= reward_sign;
                mag_q  <= reward_mag;
            end
            // step_acc is never true in APPLY, so the eligibility writes cannot collide.
            if (state == S_APPLY) begin
                w[k]    <= w_upd;
                elig[k] <= '0;
                k       <= k + 2'd1;
            end
            if (drop) overrun <= 1'b1;
        end
    end

    assign weight1 = w[0];
    assign weight2 = w[1];
    assign weight3 = w[2];
    assign weight4 = w[3];
endmodule

// File: tb/tb_snn_reward_learner.sv
// tb/tb_snn_reward_learner.sv - randomized and directed bench for snn_reward_learner
module tb_snn_reward_learner;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b1;
    logic              clear = 1'b0;
    logic              step = 1'b0;
    logic [1:0]        pre_spk = 2'd0;
    logic [1:0]        post_spk = 2'd0;
    logic              reward_valid = 1'b0;
    logic              reward_sign = 1'b0;
    logic [1:0]        reward_mag = 2'd0;
    logic signed [4:0] weight1, weight2, weight3, weight4;
    logic              busy, update_done, overrun;

    int n_checks = 0;
    int n_fail = 0;
    int m_pre [2];
    int m_post [2];
    int m_elig [4];
    int m_w [4];
    int m_wn [4];

    always #5 clk = ~clk;

    snn_reward_learner dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .step(step),
        .pre_spk(pre_spk), .post_spk(post_spk), .reward_valid(reward_valid),
        .reward_sign(reward_sign), .reward_mag(reward_mag),
        .weight1(weight1), .weight2(weight2), .weight3(weight3), .weight4(weight4),
        .busy(busy), .update_done(update_done), .overrun(overrun)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dut_w(input int n);
        case (n)
            0:       return int'(weight1);
            1:       return int'(weight2);
            2:       return int'(weight3);
            default: return int'(weight4);
        endcase
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_pre[n] = 0;
            m_post[n] = 0;
        end
        for (int n = 0; n < 4; n++) begin
            m_elig[n] = 0;
            m_w[n] = 0;
        end
    endtask

    task automatic model_step(input logic [1:0] pre, input logic [1:0] post);
        int op [2];
        int oq [2];
        int e;
        op = m_pre;
        oq = m_post;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                e = m_elig[2*i+j];
                if (post[j]) e = e + op[i] / 4;
                if (pre[i])  e = e - oq[j] / 4;
                m_elig[2*i+j] = clamp(e, -32, 31);
            end
        for (int i = 0; i < 2; i++) begin
            m_pre[i]  = pre[i]  ? 15 : clamp(op[i] - 1, 0, 15);
            m_post[i] = post[i] ? 15 : clamp(oq[i] - 1, 0, 15);
        end
    endtask

    task automatic model_targets(input logic sgn, input logic [1:0] mag);
        int d;
        for (int n = 0; n < 4; n++) begin
            d = m_elig[n] >>> (3 - int'(mag));
            m_wn[n] = clamp(sgn ? m_w[n] + d : m_w[n] - d, -16, 15);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step(input logic [1:0] pre, input logic [1:0] post, input logic en);
        ena = en; step = 1'b1; pre_spk = pre; post_spk = post;
        tick();
        step = 1'b0; pre_spk = 2'd0; post_spk = 2'd0; ena = 1'b1;
        if (en) model_step(pre, post);
    endtask

    task automatic idle_steps(input int cnt);
        for (int c = 0; c < cnt; c++) do_step(2'b00, 2'b00, 1'b1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
        check("clear_overrun", overrun, 0);
        check("clear_w1", dut_w(0), 0);
    endtask

    task automatic run_reward(input logic sgn, input logic [1:0] mag, input logic with_step,
                              input logic [1:0] pre, input logic [1:0] post);
        ena = 1'b1; reward_valid = 1'b1; reward_sign = sgn; reward_mag = mag;
        if (with_step) begin
            step = 1'b1; pre_spk = pre; post_spk = post;
        end
        tick();
        reward_valid = 1'b0; step = 1'b0; pre_spk = 2'd0; post_spk = 2'd0;
        if (with_step) model_step(pre, post);
        model_targets(sgn, mag);
        check("rw_busy_start", busy, 1);
        check("rw_done_start", update_done, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int n = 0; n < 4; n++)
                check($sformatf("rw_w%0d_k%0d", n + 1, k), dut_w(n), (n <= k) ? m_wn[n] : m_w[n]);
            check($sformatf("rw_busy_k%0d", k), busy, 1);
            check($sformatf("rw_done_k%0d", k), update_done, (k == 3) ? 1 : 0);
        end
        tick();
        check("rw_busy_end", busy, 0);
        check("rw_done_end", update_done, 0);
        m_w = m_wn;
        for (int n = 0; n < 4; n++) m_elig[n] = 0;
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", update_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_w1", dut_w(0), 0);
        #5 rst_n = 1'b1;
        tick();
        run_reward(1'b1, 2'd3, 1'b0, 2'd0, 2'd0);
        for (int n = 0; n < 4; n++) check($sformatf("rst_rw_w%0d", n + 1), dut_w(n), 0);

        // LTP
        do_step(2'b01, 2'b00, 1'b1);
        do_step(2'b00, 2'b01, 1'b1);
        run_reward(1'b1, 2'd3, 1'b0, 2'd0, 2'd0);
        check("ltp_w1", dut_w(0), 3);
        check("ltp_w2", dut_w(1), 0);
        check("ltp_w3", dut_w(2), 0);
        check("ltp_w4", dut_w(3), 0);

        // LTD, then the same pairing under negative reward
        do_clear();
        do_step(2'b00, 2'b01, 1'b1);
        do_step(2'b01, 2'b00, 1'b1);
        run_reward(1'b1, 2'd3, 1'b0, 2'd0, 2'd0);
        check("ltd_w1", dut_w(0), -3);
        idle_steps(12);
        do_step(2'b00, 2'b01, 1'b1);
        do_step(2'b01, 2'b00, 1'b1);
        run_reward(1'b0, 2'd3, 1'b0, 2'd0, 2'd0);
        check("ltd_neg_w1", dut_w(0), 0);

        // Magnitude scaling drops small eligibility to zero
        do_clear();
        do_step(2'b01, 2'b00, 1'b1);
        do_step(2'b00, 2'b01, 1'b1);
        run_reward(1'b1, 2'd1, 1'b0, 2'd0, 2'd0);
        check("scale_w1", dut_w(0), 0);

        // Saturation in both directions
        for (int s = 0; s < 2; s++) begin
            do_clear();
            for (int r = 0; r < 6; r++) begin
                idle_steps(12);
                do_step(2'b01, 2'b00, 1'b1);
                do_step(2'b00, 2'b01, 1'b1);
                run_reward((s == 0) ? 1'b1 : 1'b0, 2'd3, 1'b0, 2'd0, 2'd0);
            end
            check($sformatf("sat%0d_w1", s), dut_w(0), (s == 0) ? 15 : -16);
        end

        // Step dropped while busy
        do_clear();
        reward_valid = 1'b1; reward_sign = 1'b1; reward_mag = 2'd3;
        tick();
        reward_valid = 1'b0;
        tick();
        step = 1'b1; pre_spk = 2'b11;
        tick();
        step = 1'b0; pre_spk = 2'b00;
        check("drop_overrun", overrun, 1);
        for (int c = 0; c < 3; c++) tick();
        check("drop_busy_end", busy, 0);
        do_step(2'b00, 2'b11, 1'b1);
        run_reward(1'b1, 2'd3, 1'b0, 2'd0, 2'd0);
        check("drop_w1", dut_w(0), 0);
        check("drop_overrun_sticky", overrun, 1);
        do_clear();

        // Synchronous clear mid-APPLY
        do_step(2'b01, 2'b00, 1'b1);
        do_step(2'b00, 2'b01, 1'b1);
        reward_valid = 1'b1; reward_sign = 1'b1; reward_mag = 2'd3;
        tick();
        reward_valid = 1'b0;
        tick();
        check("clr_pre_w1", dut_w(0), 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
        check("clr_w1", dut_w(0), 0);
        check("clr_busy", busy, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("clr_done_%0d", c), update_done, 0);
            check($sformatf("clr_w2_%0d", c), dut_w(1), 0);
        end

        // Asynchronous reset mid-APPLY
        do_step(2'b01, 2'b00, 1'b1);
        do_step(2'b00, 2'b01, 1'b1);
        reward_valid = 1'b1; reward_sign = 1'b1; reward_mag = 2'd3;
        tick();
        reward_valid = 1'b0;
        tick();
        check("arst_pre_w1", dut_w(0), 3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_w1", dut_w(0), 0);
        check("arst_busy", busy, 0);
        #2 rst_n = 1'b1;
        tick();
        model_reset();
        check("arst_after_busy", busy, 0);

        // Randomized traffic against the reference model
        for (int it = 0; it < 200; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 6) begin
                do_step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0));
            end else if (op < 7) begin
                ena = 1'b0; reward_valid = 1'b1; reward_sign = 1'($urandom_range(0, 1));
                tick();
                reward_valid = 1'b0; ena = 1'b1;
                check("rnd_ena_low_busy", busy, 0);
            end else begin
                run_reward(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end
            for (int n = 0; n < 4; n++) check($sformatf("rnd%0d_w%0d", it, n + 1), dut_w(n), m_w[n]);
            check($sformatf("rnd%0d_overrun", it), overrun, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
